// File: rtl/axi_wdata_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_wdata_gen                                                |
// | Description : AXI W-channel beat generator. Each accepted AW burst is      |
// |               pushed in as a length command (AWLEN). The block turns a     |
// |               headerless source data stream into W beats, asserting WLAST  |
// |               on the final beat of every burst, and reports how many       |
// |               bursts are still waiting for data.                           |
// | Optional    : define WGEN_PERF_CNT_EN to add beat/stall performance        |
// |               counters (perf_beats, perf_stall) and their clear input      |
// |               (perf_clr).                                                  |
// | Ports       : clk, reset            - clock, synchronous active-high reset |
// |               cmd_len/valid/ready   - burst length command (AWLEN)         |
// |               src_data/valid/ready  - source write data stream             |
// |               wdata/wstrb/wlast/wvalid/wready - AXI W channel              |
// |               cmd_cnt               - commands queued (not incl. active)   |
// |               busy                  - queue non-empty or burst in progress |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_wdata_gen #(
   parameter int AXI_DW = 128,
   parameter int AXI_LW = 8,
   parameter int CMD_D  = 8,
   parameter int CMD_AW = $clog2(CMD_D + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [AXI_LW-1:0]     cmd_len,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [AXI_DW-1:0]     src_data,
   input  logic                  src_valid,
   output logic                  src_ready,
   output logic [AXI_DW-1:0]     wdata,
   output logic [AXI_DW/8-1:0]   wstrb,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
`ifdef WGEN_PERF_CNT_EN
   input  logic                  perf_clr,
   output logic [31:0]           perf_beats,
   output logic [31:0]           perf_stall,
`endif
   output logic [CMD_AW-1:0]     cmd_cnt,
   output logic                  busy
);

   localparam int PTR_W = $clog2(CMD_D);
   localparam logic [CMD_AW-1:0] C_FULL_CNT = CMD_AW'(CMD_D);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BEAT = 1'b1
   } state_t;

   state_t              st_q, st_d;
   logic [AXI_LW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CMD_AW-1:0]   cnt_q, cnt_d;
   logic [AXI_LW-1:0]   fifo_mem_q [CMD_D];

   logic                fifo_empty;
   logic                fifo_full;
   logic                push;
   logic                pop;
   logic                beat_hs;
   logic                beat_last;
   logic [AXI_LW-1:0]   fifo_head;

   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == C_FULL_CNT);
   assign fifo_head  = fifo_mem_q[rd_ptr_q];
   assign push       = cmd_valid & ~fifo_full;
   assign beat_hs    = (st_q == ST_BEAT) & src_valid & wready;
   assign beat_last  = (beat_cnt_q == '0);

   // A command is consumed either when starting from idle or on the last
   // beat of the active burst, so consecutive bursts run without a bubble.
   assign pop = ~fifo_empty & ((st_q == ST_IDLE) | (beat_hs & beat_last));

   always_comb begin
      st_d       = st_q;
      beat_cnt_d = beat_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;

      case (st_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               st_d       = ST_BEAT;
               beat_cnt_d = fifo_head;
            end
         end
         ST_BEAT: begin
            if (beat_hs) begin
               if (!beat_last) begin
                  beat_cnt_d = beat_cnt_q - AXI_LW'(1);
               end else if (!fifo_empty) begin
                  beat_cnt_d = fifo_head;
               end else begin
                  st_d = ST_IDLE;
               end
            end
         end
         default: st_d = ST_IDLE;
      endcase

      // Pointers wrap naturally because the depth is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CMD_AW'(1);
         2'b01:   cnt_d = cnt_q - CMD_AW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q       <= ST_IDLE;
         beat_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         st_q       <= st_d;
         beat_cnt_q <= beat_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read when the count says valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= cmd_len;
   end

   // W channel is a gated pass-through of the source while a burst is active.
   always_comb begin
      wvalid    = 1'b0;
      src_ready = 1'b0;
      wlast     = 1'b0;
      wdata     = '0;
      wstrb     = '0;
      if (st_q == ST_BEAT) begin
         wvalid    = src_valid;
         src_ready = wready;
         wlast     = beat_last;
         wdata     = src_data;
         wstrb     = '1;
      end
   end

   assign cmd_ready = ~fifo_full;
   assign cmd_cnt   = cnt_q;
   assign busy      = (st_q == ST_BEAT) | ~fifo_empty;

`ifdef WGEN_PERF_CNT_EN
   logic [31:0] perf_beats_q, perf_beats_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_beats_d = perf_beats_q;
      perf_stall_d = perf_stall_q;
      if (perf_clr) begin
         perf_beats_d = '0;
         perf_stall_d = '0;
      end else begin
         if (beat_hs)           perf_beats_d = perf_beats_q + 32'd1;
         if (wvalid & ~wready)  perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_beats_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_beats_q <= perf_beats_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_beats = perf_beats_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_wdata_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_wdata_gen                                             |
// | Description : Self-checking bench for axi_wdata_gen. A queue-based         |
// |               reference model tracks pending bursts and the active burst's |
// |               remaining beats; scenario tasks compare DUT outputs against  |
// |               it and against fixed expectations. Perf counter checks are   |
// |               built when WGEN_PERF_CNT_EN is defined.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_axi_wdata_gen;

   localparam int AXI_DW = 128;
   localparam int AXI_LW = 8;
   localparam int CMD_D  = 8;
   localparam int CMD_AW = $clog2(CMD_D + 1);

   logic                clk = 1'b0;
   logic                reset;
   logic [AXI_LW-1:0]   cmd_len;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [AXI_DW-1:0]   src_data;
   logic                src_valid;
   logic                src_ready;
   logic [AXI_DW-1:0]   wdata;
   logic [AXI_DW/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [CMD_AW-1:0]   cmd_cnt;
   logic                busy;
   logic                perf_clr;
`ifdef WGEN_PERF_CNT_EN
   logic [31:0]         perf_beats;
   logic [31:0]         perf_stall;
`endif

   always #5 clk = ~clk;

   axi_wdata_gen #(
      .AXI_DW (AXI_DW),
      .AXI_LW (AXI_LW),
      .CMD_D  (CMD_D),
      .CMD_AW (CMD_AW)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_len   (cmd_len),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .src_data  (src_data),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wlast     (wlast),
      .wvalid    (wvalid),
      .wready    (wready),
`ifdef WGEN_PERF_CNT_EN
      .perf_clr  (perf_clr),
      .perf_beats(perf_beats),
      .perf_stall(perf_stall),
`endif
      .cmd_cnt   (cmd_cnt),
      .busy      (busy)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   int          mq[$];     // pending burst lengths (AWLEN)
   bit          m_act;     // a burst is being transferred
   int          m_rem;     // beats remaining after the current one
   int          m_cnt;     // expected queue occupancy
   int          src_idx;   // index of the source word currently offered
   logic [31:0] m_pb;
   logic [31:0] m_ps;
   bit          m_hs;
   int          occ0;

   initial begin
      m_act = 0; m_rem = 0; m_cnt = 0; src_idx = 0; m_pb = '0; m_ps = '0;
   end

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_act = 0; m_rem = 0; m_pb = '0; m_ps = '0;
      end else begin
         occ0 = mq.size();
         m_hs = m_act && src_valid && wready;
         if (perf_clr) begin
            m_pb = '0; m_ps = '0;
         end else begin
            if (m_hs) m_pb = m_pb + 32'd1;
            if (m_act && src_valid && !wready) m_ps = m_ps + 32'd1;
         end
         if (m_hs) src_idx++;
         if (!m_act) begin
            if (occ0 > 0) begin m_rem = mq.pop_front(); m_act = 1; end
         end else if (m_hs) begin
            if (m_rem == 0) begin
               if (occ0 > 0) m_rem = mq.pop_front();
               else m_act = 0;
            end else begin
               m_rem--;
            end
         end
         if (cmd_valid && occ0 < CMD_D) mq.push_back(int'(cmd_len));
      end
      m_cnt = mq.size();
   end

   function automatic logic [AXI_DW-1:0] seq_data(input int idx);
      logic [AXI_DW-1:0] d;
      for (int i = 0; i < AXI_DW/32; i++)
         d[i*32 +: 32] = (32'h9E37_79B9 * (idx + 1)) ^ (32'h0101_0101 * i);
      return d;
   endfunction

   // Source always presents the word at src_idx (held until accepted).
   always @(negedge clk) src_data = seq_data(src_idx);

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; cmd_valid = 0; cmd_len = '0; src_valid = 1; wready = 1; perf_clr = 0;
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
      checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready got %b exp 0", src_ready); end
      checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got %b exp 0", wvalid); end
      checks++; if (wlast !== 1'b0) begin errors++; $display("FAIL reset_wlast got %b exp 0", wlast); end
      checks++; if (wdata !== '0 || wstrb !== '0) begin errors++; $display("FAIL reset_wdata_wstrb got %h/%h exp 0/0", wdata, wstrb); end
      checks++; if (cmd_cnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset_cnt_busy got %0d/%b exp 0/0", cmd_cnt, busy); end
`ifdef WGEN_PERF_CNT_EN
      checks++; if (perf_beats !== 32'd0 || perf_stall !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_beats, perf_stall); end
`endif
      src_valid = 0;
      @(negedge clk);
   endtask

   task automatic test_single();
      src_valid = 1; wready = 1; cmd_len = 8'd3; cmd_valid = 1;
      tick();                      // push edge of cycle N
      cmd_valid = 0;
      for (int i = 1; i <= 6; i++) begin
         #1;
         checks++; if (wvalid !== (i >= 2 && i <= 5)) begin errors++; $display("FAIL single_wvalid cyc N+%0d got %b exp %b", i, wvalid, (i >= 2 && i <= 5)); end
         checks++; if (wlast !== (i == 5)) begin errors++; $display("FAIL single_wlast cyc N+%0d got %b exp %b", i, wlast, (i == 5)); end
         checks++; if (busy !== (i <= 5)) begin errors++; $display("FAIL single_busy cyc N+%0d got %b exp %b", i, busy, (i <= 5)); end
         if (i == 2) begin
            checks++; if (wstrb !== '1 || wdata !== seq_data(src_idx)) begin errors++; $display("FAIL single_data got %h strb %h", wdata, wstrb); end
         end
         tick();
      end
      src_valid = 0;
   endtask

   task automatic test_back_to_back();
      int lens[3] = '{0, 1, 0};
      int nb = 0;
      int first_cyc = -1;
      int last_cyc  = -1;
      logic [3:0] pat = '0;
      src_valid = 1; wready = 1;
      for (int i = 0; i < 10; i++) begin
         cmd_valid = (i < 3);
         cmd_len   = (i < 3) ? AXI_LW'(lens[i]) : '0;
         #1;
         checks++; if (wvalid !== (m_act && src_valid) || cmd_cnt !== CMD_AW'(m_cnt)) begin errors++; $display("FAIL b2b_model cyc %0d got wvalid %b cnt %0d exp %b %0d", i, wvalid, cmd_cnt, m_act, m_cnt); end
         if (wvalid && wready) begin
            if (nb < 4) pat[3-nb] = wlast;
            if (first_cyc < 0) first_cyc = i;
            last_cyc = i;
            nb++;
         end
         tick();
      end
      cmd_valid = 0; src_valid = 0;
      checks++; if (nb !== 4) begin errors++; $display("FAIL b2b_beats got %0d exp 4", nb); end
      checks++; if (pat !== 4'b1011) begin errors++; $display("FAIL b2b_wlast_pattern got %b exp 1011", pat); end
      checks++; if (last_cyc - first_cyc !== 3) begin errors++; $display("FAIL b2b_no_bubble span got %0d exp 3", last_cyc - first_cyc); end
   endtask

   task automatic test_full();
      int done = 0;
      src_valid = 1; wready = 0; cmd_len = '0; cmd_valid = 1;
      for (int i = 0; i < 12; i++) begin
         #1;
         checks++; if (cmd_cnt !== CMD_AW'(m_cnt) || cmd_ready !== (m_cnt < CMD_D)) begin errors++; $display("FAIL full_fill cyc %0d got cnt %0d rdy %b exp %0d %b", i, cmd_cnt, cmd_ready, m_cnt, (m_cnt < CMD_D)); end
         if (i >= 9) begin
            checks++; if (cmd_ready !== 1'b0 || cmd_cnt !== CMD_AW'(8)) begin errors++; $display("FAIL full_hold cyc %0d got rdy %b cnt %0d exp 0 8", i, cmd_ready, cmd_cnt); end
         end
         tick();
      end
      wready = 1;                  // pops resume while pushes keep coming
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++; if (cmd_cnt !== CMD_AW'(m_cnt) || cmd_ready !== (m_cnt < CMD_D) || wvalid !== m_act) begin errors++; $display("FAIL full_pushpop cyc %0d got cnt %0d rdy %b exp %0d", i, cmd_cnt, cmd_ready, m_cnt); end
         tick();
      end
      cmd_valid = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         #1;
         if (!busy) done = 1;
         else tick();
      end
      checks++; if (!done || m_act || m_cnt != 0) begin errors++; $display("FAIL full_drain got busy %b exp 0 within budget", busy); end
      src_valid = 0;
   endtask

   task automatic test_backpressure();
      int  nb = 0;
      int  base;
      bit  pend = 0;
      bit  prev_wv_nohs = 0;
      bit  hs;
      base = src_idx;
      cmd_len = 8'd255; cmd_valid = 1;
      for (int i = 0; i < 4000 && nb < 256; i++) begin
         if (i == 1) cmd_valid = 0;
         src_valid = pend ? 1'b1 : ($urandom_range(0, 9) < 7);
         wready    = ($urandom_range(0, 9) < 6);
         #1;
         checks++; if (wvalid !== (m_act && src_valid)) begin errors++; $display("FAIL bp_wvalid cyc %0d got %b exp %b", i, wvalid, (m_act && src_valid)); end
         if (prev_wv_nohs && !wvalid) begin
            checks++; errors++; $display("FAIL bp_wvalid_drop cyc %0d got 0 exp 1", i);
         end
         hs = m_act && src_valid && wready;
         if (wvalid && wready) begin
            nb++;
            checks++; if (wdata !== seq_data(base + nb - 1)) begin errors++; $display("FAIL bp_data beat %0d got %h exp %h", nb, wdata, seq_data(base + nb - 1)); end
            checks++; if (wlast !== (nb == 256)) begin errors++; $display("FAIL bp_wlast beat %0d got %b exp %b", nb, wlast, (nb == 256)); end
         end
         pend = src_valid && !hs;
         prev_wv_nohs = wvalid && !wready;
         tick();
      end
      src_valid = 0; wready = 1;
      #1;
      checks++; if (nb !== 256) begin errors++; $display("FAIL bp_beat_count got %0d exp 256", nb); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end got %b exp 0", busy); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int  nb = 0;
      logic [1:0] pat = '0;
      src_valid = 1; wready = 1;
      for (int i = 0; i < 30 && nb < 5; i++) begin
         cmd_valid = (i < 2);
         cmd_len   = (i == 0) ? 8'd15 : 8'd7;
         #1;
         if (wvalid && wready) nb++;
         tick();
      end
      cmd_valid = 0;
      reset = 1;
      tick();
      reset = 0;
      #1;
      checks++; if (wvalid !== 1'b0 || cmd_cnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state got wvalid %b cnt %0d busy %b exp 0 0 0", wvalid, cmd_cnt, busy); end
      @(negedge clk);
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         cmd_valid = (i == 0);
         cmd_len   = 8'd1;
         #1;
         if (wvalid && wready) begin
            if (nb < 2) pat[1-nb] = wlast;
            nb++;
         end
         tick();
      end
      cmd_valid = 0; src_valid = 0;
      checks++; if (nb !== 2 || pat !== 2'b01) begin errors++; $display("FAIL rstmid_new_burst got %0d beats wlast %b exp 2 01", nb, pat); end
   endtask

`ifdef WGEN_PERF_CNT_EN
   task automatic test_perf();
      int nb = 0;
      int stalls = 0;
      int stall_at[3] = '{2, 5, 7};
      perf_clr = 1; tick(); perf_clr = 0;
      #1;
      checks++; if (perf_beats !== 32'd0 || perf_stall !== 32'd0) begin errors++; $display("FAIL perf_preclr got %0d/%0d exp 0/0", perf_beats, perf_stall); end
      src_valid = 1;
      for (int i = 0; i < 40 && nb < 10; i++) begin
         cmd_valid = (i == 0);
         cmd_len   = 8'd9;
         wready    = !(m_act && stalls < 3 && nb == stall_at[stalls]);
         if (!wready) stalls++;
         #1;
         if (wvalid && wready) nb++;
         tick();
      end
      cmd_valid = 0; src_valid = 0; wready = 1;
      #1;
      checks++; if (perf_beats !== 32'd10 || perf_beats !== m_pb) begin errors++; $display("FAIL perf_beats got %0d exp 10", perf_beats); end
      checks++; if (perf_stall !== 32'd3 || perf_stall !== m_ps) begin errors++; $display("FAIL perf_stall got %0d exp 3", perf_stall); end
      @(negedge clk);
      perf_clr = 1; tick(); perf_clr = 0;
      #1;
      checks++; if (perf_beats !== 32'd0 || perf_stall !== 32'd0) begin errors++; $display("FAIL perf_clr got %0d/%0d exp 0/0", perf_beats, perf_stall); end
      @(negedge clk);
   endtask
`endif

   initial begin
      reset = 1; cmd_valid = 0; cmd_len = '0; src_valid = 0; wready = 0; perf_clr = 0;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_backpressure();
      test_reset_mid();
`ifdef WGEN_PERF_CNT_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
